// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC register, debug-loaded instruction memory and IF/ID register.
// Define IF_BRANCH_FLUSH_EN to replace the delay-slot instruction with a NOP on taken branches.
module instruction_fetch #(
   parameter int                  PC_SIZE           = 32,
   parameter int                  BUS_SIZE          = 32,
   parameter int                  MEM_SIZE_IN_WORDS = 64,
   parameter logic [BUS_SIZE-1:0] HALT_WORD         = 32'hFFFFFFFF
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_stall,
   input  logic                i_next_pc_src,
   input  logic [PC_SIZE-1:0]  i_next_not_seq_pc,
   input  logic                i_mem_wr_enable,
   input  logic [BUS_SIZE-1:0] i_mem_wr_data,
   output logic [BUS_SIZE-1:0] o_instruction,
   output logic [PC_SIZE-1:0]  o_next_seq_pc,
   output logic [PC_SIZE-1:0]  o_pc,
   output logic                o_halt,
   output logic                o_mem_full,
   output logic                o_mem_empty
);

   localparam int              ADDR_W    = $clog2(MEM_SIZE_IN_WORDS);
   localparam logic [ADDR_W:0] MEM_DEPTH = (ADDR_W+1)'(MEM_SIZE_IN_WORDS);

   logic [BUS_SIZE-1:0] mem_q [MEM_SIZE_IN_WORDS];
   logic [ADDR_W:0]     loadPtr_q, loadPtr_d;
   logic [PC_SIZE-1:0]  pc_q, pc_d;
   logic [PC_SIZE-1:0]  seqPc_q, seqPc_d;
   logic [BUS_SIZE-1:0] instr_q, instr_d;
   logic                halt_q, halt_d;

   logic [PC_SIZE-1:0]  pcPlus4;
   logic [ADDR_W-1:0]   pcIdx;
   logic                pcInRange;
   logic                wordLoaded;
   logic [BUS_SIZE-1:0] fetchedWord;
   logic                isHalt;
   logic                memWrite;

   // Anything past the memory end or not yet loaded reads as HALT, so a short program stops itself.
   assign pcPlus4     = pc_q + PC_SIZE'(4);
   assign pcIdx       = pc_q[ADDR_W+1:2];
   assign pcInRange   = (pc_q >> (ADDR_W + 2)) == '0;
   assign wordLoaded  = {1'b0, pcIdx} < loadPtr_q;
   assign fetchedWord = (pcInRange && wordLoaded) ? mem_q[pcIdx] : HALT_WORD;
   assign isHalt      = fetchedWord == HALT_WORD;

   always_comb begin
      pc_d      = pc_q;
      seqPc_d   = seqPc_q;
      instr_d   = instr_q;
      halt_d    = halt_q;
      loadPtr_d = loadPtr_q;
      memWrite  = 1'b0;
      if (!halt_q && i_enable && !i_stall) begin
         instr_d = fetchedWord;
         seqPc_d = pcPlus4;
`ifdef IF_BRANCH_FLUSH_EN
         if (i_next_pc_src) begin
            instr_d = '0;
         end
`endif
         // On HALT the PC parks on the HALT word, even if ID asks for a branch.
         if (isHalt) begin
            halt_d = 1'b1;
         end else begin
            pc_d = i_next_pc_src ? i_next_not_seq_pc : pcPlus4;
         end
      end
      if (i_mem_wr_enable && (loadPtr_q != MEM_DEPTH)) begin
         memWrite  = 1'b1;
         loadPtr_d = loadPtr_q + (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_q      <= '0;
         seqPc_q   <= '0;
         instr_q   <= '0;
         halt_q    <= 1'b0;
         loadPtr_q <= '0;
      end else begin
         pc_q      <= pc_d;
         seqPc_q   <= seqPc_d;
         instr_q   <= instr_d;
         halt_q    <= halt_d;
         loadPtr_q <= loadPtr_d;
      end
   end

   // Memory contents survive reset; only the load pointer forgets them.
   always_ff @(posedge i_clk) begin
      if (memWrite && !i_reset) begin
         mem_q[loadPtr_q[ADDR_W-1:0]] <= i_mem_wr_data;
      end
   end

   assign o_instruction = instr_q;
   assign o_next_seq_pc = seqPc_q;
   assign o_pc          = pc_q;
   assign o_halt        = halt_q;
   assign o_mem_full    = loadPtr_q == MEM_DEPTH;
   assign o_mem_empty   = loadPtr_q == '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed program scenarios plus random traffic,
// every cycle compared against a word-array reference model of the fetch stage.
module tb_instruction_fetch;

   localparam int          DEPTH = 64;
   localparam logic [31:0] HALTW = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        stall = 1'b0;
   logic        pcSrc = 1'b0;
   logic [31:0] target = '0;
   logic        wrEn = 1'b0;
   logic [31:0] wrData = '0;
   logic [31:0] instruction, nextSeqPc, pc;
   logic        halt, memFull, memEmpty;

   int testsRun = 0;
   int testsFailed = 0;

   logic [31:0] mMem [DEPTH];
   int          mPtr = 0;
   logic [31:0] mPc = '0, mInstr = '0, mSeq = '0;
   logic        mHalt = 1'b0;

   instruction_fetch dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_enable          (enable),
      .i_stall           (stall),
      .i_next_pc_src     (pcSrc),
      .i_next_not_seq_pc (target),
      .i_mem_wr_enable   (wrEn),
      .i_mem_wr_data     (wrData),
      .o_instruction     (instruction),
      .o_next_seq_pc     (nextSeqPc),
      .o_pc              (pc),
      .o_halt            (halt),
      .o_mem_full        (memFull),
      .o_mem_empty       (memEmpty)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value and log any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference fetch: a word exists only below the load pointer and inside the memory.
   function automatic logic [31:0] modelFetch(input logic [31:0] addr);
      if (addr >= 32'(DEPTH * 4) || (addr >> 2) >= 32'(mPtr)) return HALTW;
      return mMem[addr >> 2];
   endfunction

   // Drive one cycle of inputs, advance the model, then compare every output.
   task automatic applyStimulus(input logic rst, input logic en, input logic stl, input logic src,
                                input logic [31:0] tgt, input logic wr, input logic [31:0] wd);
      logic [31:0] fetched;
      @(negedge clk);
      reset = rst; enable = en; stall = stl; pcSrc = src; target = tgt; wrEn = wr; wrData = wd;
      fetched = modelFetch(mPc);
      if (rst) begin
         mPc = '0; mInstr = '0; mSeq = '0; mHalt = 1'b0; mPtr = 0;
      end else begin
         if (!mHalt && en && !stl) begin
            mInstr = fetched;
            mSeq   = mPc + 32'd4;
`ifdef IF_BRANCH_FLUSH_EN
            if (src) mInstr = '0;
`endif
            if (fetched == HALTW) mHalt = 1'b1;
            else mPc = src ? tgt : mPc + 32'd4;
         end
         if (wr && mPtr < DEPTH) begin
            mMem[mPtr] = wd;
            mPtr++;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("pc", pc, mPc);
      checkOutput("instruction", instruction, mInstr);
      checkOutput("next_seq_pc", nextSeqPc, mSeq);
      checkOutput("halt", {31'b0, halt}, {31'b0, mHalt});
      checkOutput("mem_full", {31'b0, memFull}, {31'b0, mPtr == DEPTH});
      checkOutput("mem_empty", {31'b0, memEmpty}, {31'b0, mPtr == 0});
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic loadWord(input logic [31:0] w);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, w);
   endtask

   task automatic advance(input logic src, input logic [31:0] tgt);
      applyStimulus(1'b0, 1'b1, 1'b0, src, tgt, 1'b0, '0);
   endtask

   initial begin
      logic [31:0] prog [3];
      logic [31:0] word63;
      prog[0] = 32'h20010005; prog[1] = 32'h20020003; prog[2] = 32'h00221820;

      // Three-word program runs off the end into HALT.
      doReset();
      checkOutput("reset_empty", {31'b0, memEmpty}, 32'd1);
      for (int i = 0; i < 3; i++) loadWord(prog[i]);
      for (int i = 0; i < 3; i++) begin
         advance(1'b0, '0);
         checkOutput("prog_instr", instruction, prog[i]);
         checkOutput("prog_seq", nextSeqPc, 32'((i + 1) * 4));
      end
      advance(1'b0, '0);
      checkOutput("prog_halt", {31'b0, halt}, 32'd1);
      checkOutput("prog_halt_pc", pc, 32'd12);
      advance(1'b1, 32'h40);
      checkOutput("halt_hold_pc", pc, 32'd12);

      // Fill the memory, overflow once, then fetch the last word.
      doReset();
      word63 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) word63 = $urandom & 32'h7FFFFFFF;
         loadWord(i == DEPTH - 1 ? word63 : ($urandom & 32'h7FFFFFFF));
      end
      loadWord(32'h12345678);
      checkOutput("full_flag", {31'b0, memFull}, 32'd1);
      advance(1'b1, 32'hFC);
      advance(1'b0, '0);
      checkOutput("last_word", instruction, word63);

      // Stall at pc=8 with a branch request that must be ignored.
      doReset();
      for (int i = 0; i < 8; i++) loadWord(32'h1000_0000 + 32'(i));
      advance(1'b0, '0);
      advance(1'b0, '0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, '0);
         checkOutput("stall_pc", pc, 32'd8);
         checkOutput("stall_instr", instruction, 32'h1000_0001);
      end

      // Taken branch at pc=4.
      doReset();
      for (int i = 0; i < 16; i++) loadWord(32'h2000_0000 + 32'(i));
      advance(1'b0, '0);
      advance(1'b1, 32'h20);
      checkOutput("branch_pc", pc, 32'h20);
      checkOutput("branch_seq", nextSeqPc, 32'd8);
`ifdef IF_BRANCH_FLUSH_EN
      checkOutput("branch_slot", instruction, 32'h0);
`else
      checkOutput("branch_slot", instruction, 32'h2000_0001);
`endif

      // Enable low holds everything; reset mid-run at pc=0x10.
      doReset();
      for (int i = 0; i < 8; i++) loadWord(32'h3000_0000 + 32'(i));
      for (int i = 0; i < 4; i++) advance(1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      checkOutput("disabled_pc", pc, 32'h10);
      doReset();
      checkOutput("midrun_reset_pc", pc, 32'h0);

      // Branch beyond the memory end.
      for (int i = 0; i < 4; i++) loadWord(32'h4000_0000 + 32'(i));
      advance(1'b1, 32'h100);
      advance(1'b0, '0);
      checkOutput("oob_halt", {31'b0, halt}, 32'd1);
      checkOutput("oob_pc", pc, 32'h100);

      // Random traffic against the model.
      doReset();
      for (int n = 0; n < 1500; n++) begin
         logic rst, en, stl, src, wr;
         logic [31:0] tgt, wd;
         rst = ($urandom_range(99) < 2) || (mHalt && $urandom_range(9) == 0);
         en  = $urandom_range(99) < 80;
         stl = $urandom_range(99) < 20;
         src = $urandom_range(99) < 20;
         tgt = ($urandom_range(99) < 90) ? 32'($urandom_range(70)) << 2 : $urandom;
         wr  = $urandom_range(99) < 30;
         wd  = ($urandom_range(99) < 3) ? HALTW : ($urandom & 32'h7FFFFFFF);
         applyStimulus(rst, en, stl, src, tgt, wr, wd);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
